// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the divider uses a start/busy/done handshake.
package div_pkg;

  // Default widths line up with the 3x3 multiplier: 6-bit product, 3-bit factor.
  localparam int DIVIDEND_W_DEF = 6;
  localparam int DIVISOR_W_DEF  = 3;

  // Step counter must be able to count to DIVIDEND_W.
  localparam int STEP_CNT_W = $clog2(DIVIDEND_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step-counter width for a non-default dividend width.
  function automatic int step_cnt_w(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done request and result bundle for the sequential divider.
// Latency: n/a (wires only).
// Backpressure: start is honoured only while busy is low; no other flow control.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) ();

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  // Requester side: issues operands, observes results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step plus the ripple full adder it is built from.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.

// Single-bit full adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module div_step #(
  parameter int W = 3
) (
  input  logic [W:0]   pr_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   pr_o,
  output logic         qbit_o
);

  logic [W:0]   shifted;
  logic [W:0]   sub_b;
  logic [W:0]   diff;
  logic [W+1:0] carry;

  // Bring in the next dividend bit; subtract the divisor as a + ~b + 1.
  assign shifted  = {pr_i[W-1:0], bit_i};
  assign sub_b    = ~{1'b0, divisor_i};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= W; i++) begin : g_sub
    full_adder u_fa (
      .a_i (shifted[i]),
      .b_i (sub_b[i]),
      .c_i (carry[i]),
      .s_o (diff[i]),
      .c_o (carry[i+1])
    );
  end

  // Carry out means no borrow (shifted >= divisor). The dropped pr_i MSB can
  // only be set when the divisor is zero, where the bit must be 1 anyway.
  assign qbit_o = carry[W+1] | pr_i[W];
  assign pr_o   = qbit_o ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock; DIV_ZERO_CHECK_EN adds early divide-by-zero exit.
// Latency: DIVIDEND_W cycles from accepted start to done (1 cycle for a zero divisor with DIV_ZERO_CHECK_EN).
// Backpressure: start ignored while busy; a start in the done cycle is accepted back-to-back.
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave div_if
);

  localparam int CNT_W = step_cnt_w(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  // Dividend bits leave at the MSB while quotient bits fill in at the LSB.
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W:0]    pr_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;

  logic [DIVISOR_W:0]    pr_d;
  logic                  qbit_d;
  logic [DIVIDEND_W-1:0] dvd_d;

  div_step #(.W(DIVISOR_W)) u_step (
    .pr_i      (pr_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .pr_o      (pr_d),
    .qbit_o    (qbit_d)
  );

  assign dvd_d = {dvd_q[DIVIDEND_W-2:0], qbit_d};

`ifdef DIV_ZERO_CHECK_EN
  logic dbz_q;
`endif

  // Control FSM, datapath shift registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (div_if.start) begin
            dvd_q   <= div_if.dividend;
            dvs_q   <= div_if.divisor;
            pr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q   <= 1'b0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
`ifdef DIV_ZERO_CHECK_EN
          if (dvs_q == '0) begin
            quotient_q  <= '1;
            remainder_q <= dvd_q[DIVISOR_W-1:0];
            dbz_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else
`endif
          begin
            pr_q  <= pr_d;
            dvd_q <= dvd_d;
            if (cnt_q == LAST_STEP) begin
              quotient_q  <= dvd_d;
              remainder_q <= pr_d[DIVISOR_W-1:0];
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign div_if.busy      = busy_q;
  assign div_if.done      = done_q;
  assign div_if.quotient  = quotient_q;
  assign div_if.remainder = remainder_q;
`ifdef DIV_ZERO_CHECK_EN
  assign div_if.div_by_zero = dbz_q;
`else
  assign div_if.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, known quotients, exhaustive round trip, ignored start, mid-run reset, zero divisor.
// Latency: checks DIVIDEND_W-cycle start-to-done timing (1 cycle for zero divisor with DIV_ZERO_CHECK_EN).
// Backpressure: exercises start while busy and back-to-back starts in the done cycle.
module tb_seq_divider;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;

  seq_divider_if #(.DIVIDEND_W(6), .DIVISOR_W(3)) bus ();

  seq_divider #(.DIVIDEND_W(6), .DIVISOR_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_ZERO_CHECK_EN
  localparam int  ZERO_LAT = 1;
  localparam logic ZERO_DBZ = 1'b1;
`else
  localparam int  ZERO_LAT = 6;
  localparam logic ZERO_DBZ = 1'b0;
`endif

  // Issue one operation from an idle/done negedge and check its result and timing.
  task automatic do_op(input string name, input logic [5:0] dvd, input logic [2:0] dvs,
                       input logic [5:0] eq, input logic [2:0] er, input int elat, input logic edbz);
    int lat;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 6'($urandom);
    bus.divisor  = 3'($urandom);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat !== elat) begin fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat); end
    tests_run++;
    if (bus.quotient !== eq) begin fails++; $display("FAIL %s quotient: got %0d want %0d", name, bus.quotient, eq); end
    tests_run++;
    if (bus.remainder !== er) begin fails++; $display("FAIL %s remainder: got %0d want %0d", name, bus.remainder, er); end
    tests_run++;
    if (bus.div_by_zero !== edbz) begin fails++; $display("FAIL %s div_by_zero: got %b want %b", name, bus.div_by_zero, edbz); end
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL %s busy in done cycle: got %b want 0", name, bus.busy); end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL %s done pulse width: got %b want 0", name, bus.done); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL reset done: got %b want 0", bus.done); end
    tests_run++;
    if (bus.quotient !== 6'd0) begin fails++; $display("FAIL reset quotient: got %0d want 0", bus.quotient); end
    tests_run++;
    if (bus.remainder !== 3'd0) begin fails++; $display("FAIL reset remainder: got %0d want 0", bus.remainder); end
    tests_run++;
    if (bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL reset div_by_zero: got %b want 0", bus.div_by_zero); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_op("45/6", 6'd45, 3'd6, 6'd7, 3'd3, 6, 1'b0);
    do_op("63/7", 6'd63, 3'd7, 6'd9, 3'd0, 6, 1'b0);
    do_op("5/7",  6'd5,  3'd7, 6'd0, 3'd5, 6, 1'b0);
  endtask

  // Every multiplier product A*B (B nonzero) divided by B; each start lands in the previous done cycle.
  task automatic test_back_to_back;
    int lat;
    for (int b = 1; b < 8; b++) begin
      for (int a = 0; a < 8; a++) begin
        bus.dividend = 6'(a * b);
        bus.divisor  = 3'(b);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        tests_run++;
        if (lat !== 6) begin fails++; $display("FAIL b2b %0d*%0d latency: got %0d want 6", a, b, lat); end
        tests_run++;
        if (bus.quotient !== 6'(a)) begin fails++; $display("FAIL b2b %0d/%0d quotient: got %0d want %0d", a*b, b, bus.quotient, a); end
        tests_run++;
        if (bus.remainder !== 3'd0) begin fails++; $display("FAIL b2b %0d/%0d remainder: got %0d want 0", a*b, b, bus.remainder); end
      end
    end
    @(negedge clk);
  endtask

  // A second start two cycles into an operation must not disturb it.
  task automatic test_ignore_start;
    int lat;
    bus.dividend = 6'd45;
    bus.divisor  = 3'd6;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.dividend = 6'd63;
    bus.divisor  = 3'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL ignore busy: got %b want 1", bus.busy); end
    lat = 3;
    while (bus.done !== 1'b1 && lat < 20) begin
      tests_run++;
      if (bus.busy !== 1'b1) begin fails++; $display("FAIL ignore busy at %0d: got %b want 1", lat, bus.busy); end
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat !== 6) begin fails++; $display("FAIL ignore latency: got %0d want 6", lat); end
    tests_run++;
    if (bus.quotient !== 6'd7) begin fails++; $display("FAIL ignore quotient: got %0d want 7", bus.quotient); end
    tests_run++;
    if (bus.remainder !== 3'd3) begin fails++; $display("FAIL ignore remainder: got %0d want 3", bus.remainder); end
    @(negedge clk);
  endtask

  // Reset during RUN step 3 (outputs still hold 45/6 = 7 r3 from before), then a clean operation.
  task automatic test_reset_mid_run;
    bus.dividend = 6'd63;
    bus.divisor  = 3'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst done: got %b want 0", bus.done); end
    tests_run++;
    if (bus.quotient !== 6'd0) begin fails++; $display("FAIL midrst quotient: got %0d want 0", bus.quotient); end
    tests_run++;
    if (bus.remainder !== 3'd0) begin fails++; $display("FAIL midrst remainder: got %0d want 0", bus.remainder); end
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst idle: got busy %b want 0", bus.busy); end
    do_op("20/3", 6'd20, 3'd3, 6'd6, 3'd2, 6, 1'b0);
  endtask

  task automatic test_div_zero;
    do_op("45/0", 6'd45, 3'd0, 6'd63, 3'd5, ZERO_LAT, ZERO_DBZ);
    do_op("63/7 after zero", 6'd63, 3'd7, 6'd9, 3'd0, 6, 1'b0);
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    do_op("45/6 pre", 6'd45, 3'd6, 6'd7, 3'd3, 6, 1'b0);
    test_ignore_start();
    test_reset_mid_run();
    test_div_zero();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
